// File: rtl/clint_ctrl_pkg.sv
// Shared constants and state encoding for the core-local interrupt sequencer.
// Covers CSR addresses, trap/return instruction encodings and cause codes.
package clint_ctrl_pkg;

    localparam logic [11:0] INST_CSR_MEPC    = 12'h341;
    localparam logic [11:0] INST_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] INST_CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] INST_CSR_MTVEC   = 12'h305;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [63:0] CAUSE_ECALL  = 64'd11;
    localparam logic [63:0] CAUSE_EBREAK = 64'd3;

    // MSTATUS bit positions touched by trap entry and return.
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StMepc        = 3'd1,
        StMstatus     = 3'd2,
        StMcause      = 3'd3,
        StMstatusMret = 3'd4,
        StAssert      = 3'd5
    } clint_state_e;

endpackage

// File: rtl/clint_ctrl_if.sv
// Bundle of pipeline, CSR-file and redirect signals around the interrupt sequencer.
// The slave modport is the sequencer; the master modport is its surroundings.
interface clint_ctrl_if #(
    parameter int unsigned XLEN = 64
);

    logic [7:0]      int_flag_i;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] inst_addr_i;
    logic            jump_flag_i;
    logic [XLEN-1:0] jump_addr_i;
    logic            hold_flag_i;
    logic [XLEN-1:0] csr_mtvec_i;
    logic [XLEN-1:0] csr_mepc_i;
    logic [XLEN-1:0] csr_mstatus_i;
    logic            global_int_en_i;

    logic            we_o;
    logic [XLEN-1:0] waddr_o;
    logic [XLEN-1:0] data_o;
    logic            hold_flag_o;
    logic            int_assert_o;
    logic [XLEN-1:0] int_addr_o;

    modport slave (
        input  int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
        input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
        output we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );

    modport master (
        output int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
        output csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
        input  we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );

endinterface

// File: rtl/clint_ctrl.sv
// Trap/return sequencer: stalls the pipeline, writes MEPC/MSTATUS/MCAUSE through the
// secondary CSR port, then issues a one-cycle fetch redirect to MTVEC or MEPC.
module clint_ctrl
    import clint_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] ASYNC_CAUSE = XLEN'(64'h8000_0000_0000_0007)
) (
    input logic         clk,
    input logic         rst,
    clint_ctrl_if.slave bus
);

    localparam logic [XLEN-1:0] MieMask  = XLEN'(1) << MSTATUS_MIE_BIT;
    localparam logic [XLEN-1:0] MpieMask = XLEN'(1) << MSTATUS_MPIE_BIT;

    clint_state_e    state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            mret_q, mret_d;
    logic            rst_q;

    logic            is_ecall, is_ebreak, is_mret, async_req, trig, quiet;
    logic [XLEN-1:0] mstatus_trap, mstatus_mret;

    assign is_ecall  = (bus.inst_i == INST_ECALL);
    assign is_ebreak = (bus.inst_i == INST_EBREAK);
    assign is_mret   = (bus.inst_i == INST_MRET);
    assign async_req = (|bus.int_flag_i) & bus.global_int_en_i & ~bus.hold_flag_i;

    // Outputs stay silent during reset and the cycle after; no trigger is taken then either,
    // so a stalled-but-unserviced instruction can never occur.
    assign quiet = rst | rst_q;
    assign trig  = ~rst_q & (state_q == StIdle) & (is_ecall | is_ebreak | is_mret | async_req);

    // Entry: MPIE <= MIE, MIE <= 0.  Return: MIE <= MPIE, MPIE <= 1.
    assign mstatus_trap = (bus.csr_mstatus_i & ~(MieMask | MpieMask))
                        | (bus.csr_mstatus_i[MSTATUS_MIE_BIT] ? MpieMask : '0);
    assign mstatus_mret = (bus.csr_mstatus_i & ~(MieMask | MpieMask)) | MpieMask
                        | (bus.csr_mstatus_i[MSTATUS_MPIE_BIT] ? MieMask : '0);

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        mret_d  = mret_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    if (is_ecall) begin
                        state_d = StMepc;
                        epc_d   = bus.inst_addr_i;
                        cause_d = XLEN'(CAUSE_ECALL);
                        mret_d  = 1'b0;
                    end else if (is_ebreak) begin
                        state_d = StMepc;
                        epc_d   = bus.inst_addr_i;
                        cause_d = XLEN'(CAUSE_EBREAK);
                        mret_d  = 1'b0;
                    end else if (is_mret) begin
                        state_d = StMstatusMret;
                        mret_d  = 1'b1;
                    end else begin
                        // A jump resolving in EX means the next instruction to run is its target.
                        state_d = StMepc;
                        epc_d   = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
                        cause_d = ASYNC_CAUSE;
                        mret_d  = 1'b0;
                    end
                end
            end
            StMepc:        state_d = StMstatus;
            StMstatus:     state_d = StMcause;
            StMcause:      state_d = StAssert;
            StMstatusMret: state_d = StAssert;
            StAssert:      state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= StIdle;
            epc_q   <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mret_q  <= mret_d;
        end
    end

    always_comb begin
        bus.we_o         = 1'b0;
        bus.waddr_o      = '0;
        bus.data_o       = '0;
        bus.int_assert_o = 1'b0;
        bus.int_addr_o   = '0;
        if (!quiet) begin
            unique case (state_q)
                StMepc: begin
                    bus.we_o    = 1'b1;
                    bus.waddr_o = XLEN'(INST_CSR_MEPC);
                    bus.data_o  = epc_q;
                end
                StMstatus: begin
                    bus.we_o    = 1'b1;
                    bus.waddr_o = XLEN'(INST_CSR_MSTATUS);
                    bus.data_o  = mstatus_trap;
                end
                StMcause: begin
                    bus.we_o    = 1'b1;
                    bus.waddr_o = XLEN'(INST_CSR_MCAUSE);
                    bus.data_o  = cause_q;
                end
                StMstatusMret: begin
                    bus.we_o    = 1'b1;
                    bus.waddr_o = XLEN'(INST_CSR_MSTATUS);
                    bus.data_o  = mstatus_mret;
                end
                StAssert: begin
                    bus.int_assert_o = 1'b1;
                    bus.int_addr_o   = mret_q ? bus.csr_mepc_i : bus.csr_mtvec_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.hold_flag_o = ~quiet & ((state_q != StIdle) | trig);

endmodule

// File: doc/clint_ctrl.md
Name: clint_ctrl

Overview:
- Core-local interrupt/exception sequencer that owns the CSR file's secondary (clint) write port.
- On ECALL, EBREAK or an enabled asynchronous interrupt, it stalls the pipeline and writes MEPC, MSTATUS and MCAUSE in order. It then redirects fetch to MTVEC.
- On MRET, it restores MSTATUS and redirects fetch to MEPC.
- Sits between the ID/EX stages, the CSR file and the PC/ctrl block.

Parameters:
XLEN, 64, data/address width
ASYNC_CAUSE, 64'h8000_0000_0000_0007, MCAUSE value for the asynchronous (machine timer) interrupt

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
int_flag_i  input  8  external interrupt lines; any nonzero bit = request
inst_i  input  32  instruction currently in ID
inst_addr_i  input  XLEN  PC of inst_i
jump_flag_i  input  1  EX is taking a branch/jump this cycle
jump_addr_i  input  XLEN  EX jump target
hold_flag_i  input  1  EX busy (e.g. multi-cycle divide); blocks async entry
csr_mtvec_i  input  XLEN  current MTVEC from CSR file
csr_mepc_i  input  XLEN  current MEPC
csr_mstatus_i  input  XLEN  current MSTATUS
global_int_en_i  input  1  MSTATUS.MIE from CSR file
we_o  output  1  CSR write enable (clint port)
waddr_o  output  XLEN  CSR write address (bits 11:0 significant, upper bits 0)
data_o  output  XLEN  CSR write data
hold_flag_o  output  1  stall request to ctrl
int_assert_o  output  1  one-cycle redirect strobe
int_addr_o  output  XLEN  redirect target, valid with int_assert_o

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high.
- Reset sets state IDLE and clears the latched epc/cause. While rst is high and in the cycle after, all outputs are 0.
- Reset mid-sequence aborts to IDLE. CSR writes already issued are not undone.
- Triggers are sampled only in IDLE. Priority: sync (ECALL 32'h00000073 / EBREAK 32'h00100073) > MRET (32'h30200073) > async.
- Async trigger condition: int_flag_i != 0, global_int_en_i = 1, hold_flag_i = 0.
- Latched values at trigger edge E0:
  - ECALL: cause = 11, epc = inst_addr_i.
  - EBREAK: cause = 3, epc = inst_addr_i.
  - Async: cause = ASYNC_CAUSE, epc = jump_flag_i ? jump_addr_i : inst_addr_i.
- Exception sequence (states MEPC -> MSTATUS -> MCAUSE -> ASSERT -> IDLE, one cycle each):
  - MEPC: we_o=1, waddr_o=12'h341, data_o=epc.
  - MSTATUS: we_o=1, waddr_o=12'h300, data_o = csr_mstatus_i with bit7 (MPIE) <= bit3 and bit3 (MIE) <= 0; all other bits unchanged.
  - MCAUSE: we_o=1, waddr_o=12'h342, data_o=cause.
  - ASSERT: we_o=0, int_assert_o=1, int_addr_o=csr_mtvec_i.
  - Total: 4 cycles after E0, redirect in the 4th.
- MRET sequence (MSTATUS_MRET -> ASSERT -> IDLE):
  - MSTATUS_MRET: data_o = csr_mstatus_i with bit3 <= bit7 and bit7 <= 1.
  - ASSERT: int_addr_o = csr_mepc_i.
- Outputs are combinational decode of state plus latched regs. When not writing: we_o=0, waddr_o=0, data_o=0. When not asserting: int_assert_o=0, int_addr_o=0.
- hold_flag_o = (state != IDLE) | trigger condition in IDLE, so the triggering instruction is frozen in ID during the trigger cycle.
- Triggers arriving while state != IDLE are ignored. Async requests are level-sensitive and are re-evaluated on return to IDLE. MIE is now 0, so no re-entry occurs until software or MRET sets it.
- Simultaneous ECALL and asserted int_flag_i: ECALL wins; async is taken later only if still pending and enabled.
- Sync triggers ignore hold_flag_i. The ID-stage instruction is already valid.

Decomposition:
- Shared defines file holds: INST_CSR_MEPC/MSTATUS/MCAUSE/MTVEC addresses; INST_ECALL/EBREAK/MRET encodings; state encodings (3-bit: IDLE, MEPC, MSTATUS, MCAUSE, MSTATUS_MRET, ASSERT); cause constants.
- Single module, no sub-module. The MSTATUS bit-manipulation is two continuous expressions.

Test Plan:
- ECALL at inst_addr_i=0x100, mtvec=0x200, mstatus=0x8: hold_flag_o high 5 cycles. Writes 0x341<-0x100, 0x300<-0x80, 0x342<-11 on consecutive cycles. Then int_assert_o=1 with int_addr_o=0x200 for exactly one cycle.
- Async int_flag_i=0x01, MIE=1, jump_flag_i=1, jump_addr_i=0x340: MEPC<-0x340, MCAUSE<-64'h8000_0000_0000_0007, redirect to mtvec. Repeat with MIE=0 or hold_flag_i=1: no writes, hold_flag_o=0.
- MRET with mstatus=0x80, mepc=0x104: single write 0x300<-0x88, next cycle int_assert_o=1, int_addr_o=0x104, then IDLE.
- ECALL in ID with int_flag_i=0x01 and MIE=1 in the same cycle: MCAUSE<-11. With int_flag_i held and MIE cleared by the sequence, no second entry.
- rst asserted during MSTATUS state: next cycle all outputs 0, state IDLE. A fresh ECALL afterwards runs the full 4-cycle sequence from MEPC.
